riscv_data_mem: RTL and testbench

Word-organised data memory that terminates the LSU memory interface: it accepts a held request (req/we/be/addr/wd), waits a fixed number of cycles, then completes it with a one-cycle ready pulse, returning read data or committing a byte-enabled write. It sits between the core's LSU and the data RAM and models configurable wait states, so LSU stall behaviour can be exercised. Out-of-range accesses complete normally with an error flag.

---
 rtl/riscv_data_mem.sv | 106 ++++++++++
 tb/tb_riscv_data_mem.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem.sv
// Word-organised data memory behind the LSU: accepts a held request, waits LATENCY
// cycles, then completes with a one-cycle ready pulse (read data or byte-enabled write).
module riscv_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  // state | meaning
  // IDLE  | waiting for mem_req_i; inputs latched on acceptance
  // WAIT  | wait states, counter runs down to 0; dropped req aborts
  // RESP  | ready pulse; write commits on the edge leaving this state

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wd;
  logic [31:0]   mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (AW + 2)) == 32'd0;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    return in_range(a) ? mem[a[AW+1:2]] : 32'd0;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_rd_o    <= 32'd0;
      lat_we      <= 1'b0;
      lat_be      <= 4'd0;
      lat_addr    <= 32'd0;
      lat_wd      <= 32'd0;
    end else begin
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req_i) begin
            lat_we   <= mem_we_i;
            lat_be   <= mem_be_i;
            lat_addr <= mem_addr_i;
            lat_wd   <= mem_wd_i;
            if (LATENCY == 1) begin
              // no wait states: the response is built straight from the live inputs
              state       <= RESP;
              mem_ready_o <= 1'b1;
              mem_err_o   <= !in_range(mem_addr_i);
              mem_rd_o    <= read_word(mem_addr_i);
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!mem_req_i) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state       <= RESP;
            mem_ready_o <= 1'b1;
            mem_err_o   <= !in_range(lat_addr);
            mem_rd_o    <= read_word(lat_addr);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset during RESP suppresses the pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == RESP && lat_we && in_range(lat_addr)) begin
      for (int k = 0; k < 4; k++) begin
        if (lat_be[k]) mem[lat_addr[AW+1:2]][8*k +: 8] <= lat_wd[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: three instances at LATENCY 2, 1 and 4 share one clock.
module tb_riscv_data_mem;

  localparam int LATS [3] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        req  [3];
  logic        we   [3];
  logic [3:0]  be   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        rdy  [3];
  logic        err  [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_data_mem #(.DEPTH_WORDS(1024), .LATENCY(LATS[g])) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .mem_req_i  (req[g]),
      .mem_we_i   (we[g]),
      .mem_be_i   (be[g]),
      .mem_addr_i (addr[g]),
      .mem_wd_i   (wd[g]),
      .mem_rd_o   (rd[g]),
      .mem_ready_o(rdy[g]),
      .mem_err_o  (err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drives one transaction on unit u, measures cycles to ready, checks err/rd, then idles.
  task automatic xact(input int u, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic exp_err, input logic chk_rd,
                      input logic [31:0] exp_rd, input string tag);
    int k;
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; be[u] = b; addr[u] = a; wd[u] = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy[u] && k < 20);
    chk({tag, "_lat"}, 32'(k), 32'(LATS[u]));
    chk({tag, "_err"}, {31'd0, err[u]}, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_rd"}, rd[u], exp_rd);
    req[u] = 1'b0;
    addr[u] = 32'hFFFF_FFFC;
    @(negedge clk);
    chk({tag, "_rdy_low"}, {31'd0, rdy[u]}, 32'd0);
    chk({tag, "_err_low"}, {31'd0, err[u]}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'd0; addr[i] = 32'd0; wd[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdy", {31'd0, rdy[i]}, 32'd0);
      chk("reset_err", {31'd0, err[i]}, 32'd0);
      chk("reset_rd", rd[i], 32'd0);
    end
    rst = 1'b0;

    // LATENCY=2 write then read
    xact(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 0, "wr10");
    xact(0, 0, 4'h0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "rd10");

    // byte lanes
    xact(0, 1, 4'hF, 32'h20, 32'h11223344, 0, 0, 0, "wr20");
    xact(0, 1, 4'b0100, 32'h20, 32'hAAAAAAAA, 0, 0, 0, "wr20_lane2");
    xact(0, 0, 4'hF, 32'h20, 32'h0, 0, 1, 32'h11AA3344, "rd20_lane2");
    xact(0, 1, 4'b0000, 32'h22, 32'hBBBBBBBB, 0, 0, 0, "wr20_nobe");
    xact(0, 0, 4'h0, 32'h20, 32'h0, 0, 1, 32'h11AA3344, "rd20_nobe");

    // out of range
    xact(0, 1, 4'hF, 32'h0, 32'hCAFEF00D, 0, 0, 0, "wr0");
    xact(0, 1, 4'hF, 32'h1000, 32'h55555555, 1, 0, 0, "wr_oor");
    xact(0, 0, 4'h0, 32'h1000, 32'h0, 1, 1, 32'h0, "rd_oor");
    xact(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hCAFEF00D, "rd0_after_oor");

    // reset in WAIT of a write to 0x8
    xact(0, 1, 4'hF, 32'h8, 32'h5, 0, 0, 0, "wr8");
    xact(0, 0, 4'h0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, "rd10_pre_rst");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h8; wd[0] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_wait_rdy", {31'd0, rdy[0]}, 32'd0);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, rdy[0]}, 32'd0);
    chk("rst_err", {31'd0, err[0]}, 32'd0);
    chk("rst_rd", rd[0], 32'd0);
    rst = 1'b0;
    xact(0, 0, 4'h0, 32'h8, 32'h0, 0, 1, 32'h5, "rd8_after_rst");

    // LATENCY=1 back-to-back with req held high
    xact(1, 1, 4'hF, 32'h0, 32'h01020304, 0, 0, 0, "l1_wr0");
    xact(1, 1, 4'hF, 32'h4, 32'hA5A5_5A5A, 0, 0, 0, "l1_wr4");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h0;
    @(negedge clk);
    chk("b2b_c1_rdy", {31'd0, rdy[1]}, 32'd1);
    chk("b2b_c1_rd", rd[1], 32'h01020304);
    addr[1] = 32'h4;
    @(negedge clk);
    chk("b2b_c2_rdy", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    chk("b2b_c3_rdy", {31'd0, rdy[1]}, 32'd1);
    chk("b2b_c3_rd", rd[1], 32'hA5A5_5A5A);
    req[1] = 1'b0;
    @(negedge clk);
    chk("b2b_c4_rdy", {31'd0, rdy[1]}, 32'd0);

    // LATENCY=4 abort in WAIT
    xact(2, 1, 4'hF, 32'h30, 32'h12345678, 0, 0, 0, "l4_wr30");
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h30; wd[2] = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[2]) seen++;
    end
    chk("abort_no_rdy", 32'(seen), 32'd0);
    xact(2, 0, 4'h0, 32'h30, 32'h0, 0, 1, 32'h12345678, "abort_rd30");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
